divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//  Sequential unsigned 32/32 divider for the MIPS-Lite pipeline; inverse companion of the multiplier.
//  Triggered by the DIVU funct code on Signal; one restoring-division iteration per clock.
//  Result is packed HI/LO style: HI = remainder, LO = quotient; held until the next division completes.
//  The EX stage stalls on busy and reads dataOut on or after the done cycle.
// PARAMETERS
//  WIDTH  32         operand width; dataOut is 2*WIDTH
//  DIVU   6'b011011  Signal funct code that starts a division
// PORTS
//  clk      in   1        rising-edge clock
//  reset    in   1        asynchronous, active-high reset
//  dataA    in   WIDTH    dividend (unsigned)
//  dataB    in   WIDTH    divisor (unsigned)
//  Signal   in   6        funct code; only DIVU acts, all others ignored
//  dataOut  out  2*WIDTH  {remainder, quotient}
//  busy     out  1        high while iterating; new DIVU ignored
//  done     out  1        one-cycle pulse: dataOut just updated
//  divZero  out  1        last completed division had dataB==0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, dataOut=0, busy=0, done=0, divZero=0, counter=0,
//   internal rem/quot/divisor regs=0. An in-flight division is discarded.
//  FSM states: IDLE, CALC, DONE.
//  IDLE: at edge N with Signal==DIVU:
//   - dataB!=0: latch dividend->quot reg, dataB->divisor reg, rem(WIDTH+1 bits)=0, count=0,
//     divZero<=0, busy<=1, ->CALC.
//   - dataB==0: dataOut<={dataA, all-ones}, divZero<=1, ->DONE (no CALC cycles).
//   Signal!=DIVU: stay IDLE, all outputs hold.
//  CALC: each edge N+1..N+WIDTH, one iteration:
//   t = {rem[WIDTH-1:0], quot[WIDTH-1]} - {1'b0, divisor} (WIDTH+1 bits);
//   if t[WIDTH]==0: rem=t, quot={quot[WIDTH-2:0],1} else rem={rem,quot MSB}, quot={quot,0}.
//   count++; on the WIDTH-th iteration (edge N+WIDTH): dataOut<={final rem[WIDTH-1:0], final quot},
//   busy<=0, ->DONE.
//  DONE: done=1 for exactly one cycle, then ->IDLE on next edge. A DIVU present in the DONE cycle
//   is ignored; a new division starts only from IDLE.
//  Latency: DIVU sampled at edge N -> done high in cycle after edge N+WIDTH (N+33 edge returns IDLE);
//   div-by-zero: done high in cycle after edge N.
//  busy: high from edge N through edge N+WIDTH exclusive of DONE; low in IDLE and DONE.
//  dataA/dataB/Signal changes during CALC have no effect (operands latched).
//  dataOut changes only at completion edges or reset; never shows partial results.
//  Arithmetic: unsigned only; quotient/remainder satisfy dataA == q*dataB + r, r < dataB.
// TESTING
//  1. reset; DIVU, A=100, B=7 -> busy 32 cycles, done pulse, dataOut={32'd2,32'd14}, divZero=0.
//  2. A=32'hFFFF_FFFF, B=1 -> dataOut={0,32'hFFFF_FFFF}; A=3,B=10 -> {32'd3,32'd0}.
//  3. A=5, B=0 -> done next cycle, busy never high, dataOut={32'd5,32'hFFFF_FFFF}, divZero=1.
//  4. Start 1000/3, change dataA/dataB and hold DIVU mid-CALC -> result still {1,333}; only one done.
//  5. Assert reset at iteration 10 -> immediately busy=0, done=0, dataOut=0; next DIVU 9/2 -> {1,4}.
//  6. Random 1000 unsigned pairs vs reference model; check q*B+r==A, r<B, done latency == 33 edges.

Source files
------------

// File: rtl/divider.sv
// Sequential unsigned WIDTH/WIDTH restoring divider, one quotient bit per clock.
// Result is packed {remainder, quotient} and held until the next division completes.
module divider #(
  parameter int unsigned WIDTH = 32,
  parameter logic [5:0]  DIVU  = 6'b011011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output logic               divZero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] quot, quot_n;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   shifted, diff;
  logic             start, last;

  assign start = (state == IDLE) && (Signal == DIVU);
  assign last  = (count == CW'(WIDTH - 1));

  // A non-negative trial difference is always below the divisor, so the
  // remainder never needs its extra top bit once stored.
  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_n  = diff[WIDTH-1:0];
      quot_n = {quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_n  = shifted[WIDTH-1:0];
      quot_n = {quot[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = (dataB == '0) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut <= '0;
      divZero <= 1'b0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (dataB == '0) begin
              dataOut <= {dataA, {WIDTH{1'b1}}};
              divZero <= 1'b1;
            end else begin
              quot    <= dataA;
              divisor <= dataB;
              rem     <= '0;
              count   <= '0;
              divZero <= 1'b0;
            end
          end
        end
        CALC: begin
          rem   <= rem_n;
          quot  <= quot_n;
          count <= count + 1'b1;
          if (last) dataOut <= {rem_n, quot_n};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: latency, busy window, done pulse,
// divide-by-zero, operand isolation during iteration and mid-division reset.
module tb_divider;

  localparam logic [5:0] DIVU = 6'b011011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy, done, divZero;

  int total = 0;
  int bad   = 0;

  divider #(.WIDTH(32), .DIVU(6'b011011)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
    .dataOut(dataOut), .busy(busy), .done(done), .divZero(divZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one DIVU and follow it to completion with a bounded wait.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic dz);
    int edges;
    int busy_cnt;
    dataA  = a;
    dataB  = b;
    Signal = DIVU;
    tick();
    Signal = '0;
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 100) begin
      busy_cnt += int'(busy);
      tick();
      edges++;
    end
    check({tag, " latency"}, 64'(edges), dz ? 64'd0 : 64'd32);
    check({tag, " busy cycles"}, 64'(busy_cnt), dz ? 64'd0 : 64'd32);
    check({tag, " result"}, dataOut, {r, q});
    check({tag, " divZero"}, 64'(divZero), 64'(dz));
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    tick();
    check({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int edges;
    int extra;
    reset  = 1'b1;
    Signal = '0;
    dataA  = '0;
    dataB  = '0;
    #1;
    check("reset dataOut", dataOut, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset divZero", 64'(divZero), 64'd0);
    #12;
    reset = 1'b0;
    tick();

    // Neighbouring funct code must not start anything
    dataA  = 32'd50;
    dataB  = 32'd3;
    Signal = 6'b011010;
    repeat (3) tick();
    check("non-DIVU busy", 64'(busy), 64'd0);
    check("non-DIVU done", 64'(done), 64'd0);
    check("non-DIVU dataOut", dataOut, 64'd0);
    Signal = '0;
    tick();

    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_div("3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
    run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    run_div("2^31/2^16", 32'h8000_0000, 32'h0001_0000, 32'h0000_8000, 32'd0, 1'b0);
    run_div("max/10", 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 32'd5, 1'b0);

    // Operands and DIVU changing mid-iteration must be ignored
    dataA  = 32'd1000;
    dataB  = 32'd3;
    Signal = DIVU;
    tick();
    Signal = '0;
    repeat (5) tick();
    dataA  = 32'd77;
    dataB  = 32'd5;
    Signal = DIVU;
    repeat (20) tick();
    Signal = '0;
    edges = 25;
    while (!done && edges < 100) begin
      tick();
      edges++;
    end
    check("midchange latency", 64'(edges), 64'd32);
    check("midchange result", dataOut, {32'd1, 32'd333});
    Signal = DIVU;
    tick();
    Signal = '0;
    check("DIVU in DONE ignored", 64'(busy), 64'd0);
    extra = 0;
    repeat (40) begin
      tick();
      extra += int'(done) + int'(busy);
    end
    check("midchange single done", 64'(extra), 64'd0);
    check("midchange result held", dataOut, {32'd1, 32'd333});

    run_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_div("123456789/1000", 32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0);
    run_div("0/0", 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Asynchronous reset part-way through an iteration
    dataA  = 32'd1000;
    dataB  = 32'd3;
    Signal = DIVU;
    tick();
    Signal = '0;
    repeat (10) tick();
    check("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset dataOut", dataOut, 64'd0);
    check("midreset divZero", 64'(divZero), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post-reset idle", 64'(busy), 64'd0);
    run_div("9/2", 32'd9, 32'd2, 32'd4, 32'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
